// File: rtl/nios_memory_arbiter_pkg.sv
// Shared definitions for the two-master on-chip RAM arbiter.
package nios_memory_arbiter_pkg;

   localparam int unsigned DEF_ADDR_W = 12;
   localparam int unsigned DEF_DATA_W = 32;
   localparam int unsigned HOLD_W     = 4;

   typedef enum logic {
      GRANT_M0 = 1'b0,
      GRANT_M1 = 1'b1
   } grant_e;

   function automatic logic [1:0] grant_onehot(input grant_e g);
      return (g == GRANT_M1) ? 2'b10 : 2'b01;
   endfunction

   function automatic grant_e grant_other(input grant_e g);
      return (g == GRANT_M0) ? GRANT_M1 : GRANT_M0;
   endfunction

endpackage

// File: rtl/nios_memory_arbiter_if.sv
// Bus bundle: two Avalon-style masters plus the shared RAM port.
interface nios_memory_arbiter_if
   import nios_memory_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W
);

   localparam int unsigned BE_W = DATA_W / 8;

   logic [ADDR_W-1:0] m0_address;
   logic [BE_W-1:0]   m0_byteenable;
   logic              m0_read;
   logic              m0_write;
   logic [DATA_W-1:0] m0_writedata;
   logic              m0_waitrequest;
   logic [DATA_W-1:0] m0_readdata;
   logic              m0_readdatavalid;

   logic [ADDR_W-1:0] m1_address;
   logic [BE_W-1:0]   m1_byteenable;
   logic              m1_read;
   logic              m1_write;
   logic [DATA_W-1:0] m1_writedata;
   logic              m1_waitrequest;
   logic [DATA_W-1:0] m1_readdata;
   logic              m1_readdatavalid;

   logic [ADDR_W-1:0] mem_address;
   logic [BE_W-1:0]   mem_byteenable;
   logic [DATA_W-1:0] mem_writedata;
   logic              mem_chipselect;
   logic              mem_write;
   logic              mem_clken;
   logic [DATA_W-1:0] mem_readdata;

   // Arbiter side
   modport slave (
      input  m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
      output m0_waitrequest, m0_readdata, m0_readdatavalid,
      input  m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
      output m1_waitrequest, m1_readdata, m1_readdatavalid,
      output mem_address, mem_byteenable, mem_writedata,
      output mem_chipselect, mem_write, mem_clken,
      input  mem_readdata
   );

   // Environment side: the two masters and the RAM
   modport master (
      output m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
      input  m0_waitrequest, m0_readdata, m0_readdatavalid,
      output m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
      input  m1_waitrequest, m1_readdata, m1_readdatavalid,
      input  mem_address, mem_byteenable, mem_writedata,
      input  mem_chipselect, mem_write, mem_clken,
      output mem_readdata
   );

endinterface

// File: rtl/nios_memory_arbiter_rr.sv
// Two-requester round-robin arbiter with a per-owner burst hold counter.
module nios_rr_arbiter
   import nios_memory_arbiter_pkg::*;
#(
   parameter int unsigned HOLD_MAX = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   output logic [1:0] grant
);

   localparam int unsigned HOLD_CLAMP =
      (HOLD_MAX < 1) ? 1 : ((HOLD_MAX > 15) ? 15 : HOLD_MAX);
   localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_CLAMP);

   grant_e            last_grant;
   grant_e            pick;
   logic [HOLD_W-1:0] hold_cnt;
   logic              keep_owner;

   // Choose a winner; a zero hold count means the previous cycle was idle,
   // so there is no current owner and a tie goes round-robin.
   always_comb begin
      pick       = last_grant;
      keep_owner = (hold_cnt != '0) && (hold_cnt < HOLD_LIM);
      case (req)
         2'b01:   pick = GRANT_M0;
         2'b10:   pick = GRANT_M1;
         2'b11:   pick = keep_owner ? last_grant : grant_other(last_grant);
         default: pick = last_grant;
      endcase
      grant = (req != 2'b00) ? grant_onehot(pick) : 2'b00;
   end

   // Track the last accepting master and its run length; the counter
   // saturates so a lone streaming master cannot wrap back to zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_grant <= GRANT_M1;
         hold_cnt   <= '0;
      end else if (grant != 2'b00) begin
         last_grant <= pick;
         if (pick != last_grant) begin
            hold_cnt <= HOLD_W'(1);
         end else if (hold_cnt != '1) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
         end
      end else begin
         hold_cnt <= '0;
      end
   end

endmodule

// File: rtl/nios_memory_arbiter.sv
// Two-master arbiter for a single-port synchronous on-chip RAM.
module nios_memory_arbiter
   import nios_memory_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W   = DEF_ADDR_W,
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter int unsigned HOLD_MAX = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   nios_memory_arbiter_if.slave bus
);

   localparam int unsigned BE_W = DATA_W / 8;

   logic [1:0]        req;
   logic [1:0]        grant;
   logic [ADDR_W-1:0] sel_address;
   logic [BE_W-1:0]   sel_byteenable;
   logic [DATA_W-1:0] sel_writedata;
   logic              sel_read;
   logic              sel_write;
   logic              acc_read;
   logic              rd_pend;
   grant_e            rd_owner;
   logic              rdv0;
   logic              rdv1;
   logic [DATA_W-1:0] rdata;

   // Requests are masked during reset so nothing can be accepted.
   always_comb begin
      req[0] = ~reset & (bus.m0_read | bus.m0_write);
      req[1] = ~reset & (bus.m1_read | bus.m1_write);
   end

   nios_rr_arbiter #(
      .HOLD_MAX(HOLD_MAX)
   ) u_rr_arbiter (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .grant (grant)
   );

   // Select the granted master's request; all zero when nobody is granted.
   always_comb begin
      sel_address    = '0;
      sel_byteenable = '0;
      sel_writedata  = '0;
      sel_read       = 1'b0;
      sel_write      = 1'b0;
      if (grant[0]) begin
         sel_address    = bus.m0_address;
         sel_byteenable = bus.m0_byteenable;
         sel_writedata  = bus.m0_writedata;
         sel_read       = bus.m0_read;
         sel_write      = bus.m0_write;
      end else if (grant[1]) begin
         sel_address    = bus.m1_address;
         sel_byteenable = bus.m1_byteenable;
         sel_writedata  = bus.m1_writedata;
         sel_read       = bus.m1_read;
         sel_write      = bus.m1_write;
      end
      // read+write together is a write, so it never produces read data
      acc_read = sel_read & ~sel_write;
   end

   // Drive the RAM port and per-master waitrequest.
   always_comb begin
      bus.mem_address    = sel_address;
      bus.mem_byteenable = sel_byteenable;
      bus.mem_writedata  = sel_writedata;
      bus.mem_chipselect = |grant;
      bus.mem_write      = sel_write;
      bus.mem_clken      = 1'b1;
      bus.m0_waitrequest = ~grant[0];
      bus.m1_waitrequest = ~grant[1];
   end

   // Remember which master issued the read whose data returns next cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_pend  <= 1'b0;
         rd_owner <= GRANT_M0;
      end else begin
         rd_pend <= acc_read;
         if (acc_read) begin
            rd_owner <= grant[1] ? GRANT_M1 : GRANT_M0;
         end
      end
   end

   // Route RAM read data to the issuing master only.
   always_comb begin
      rdata                = bus.mem_readdata;
      rdv0                 = rd_pend & (rd_owner == GRANT_M0);
      rdv1                 = rd_pend & (rd_owner == GRANT_M1);
      bus.m0_readdatavalid = rdv0;
      bus.m1_readdatavalid = rdv1;
      bus.m0_readdata      = rdv0 ? rdata : '0;
      bus.m1_readdata      = rdv1 ? rdata : '0;
   end

endmodule

// File: tb/tb_nios_memory_arbiter.sv
// Self-checking bench for nios_memory_arbiter with a behavioural RAM and model.
module tb_nios_memory_arbiter;

   localparam int unsigned AW   = 12;
   localparam int unsigned DW   = 32;
   localparam int unsigned BW   = DW / 8;
   localparam int unsigned HOLD = 4;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   nios_memory_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   nios_memory_arbiter #(
      .ADDR_W   (AW),
      .DATA_W   (DW),
      .HOLD_MAX (HOLD)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
                                           input logic [DW-1:0] wd,
                                           input logic [BW-1:0] be);
      logic [DW-1:0] r;
      r = old;
      for (int b = 0; b < BW; b++)
         if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   // Synchronous RAM: data for the address presented at an edge appears after it.
   logic [DW-1:0] ram [0:4095] = '{default: '0};
   always @(posedge clk) begin
      if (bus.mem_chipselect && bus.mem_clken) begin
         if (bus.mem_write)
            ram[bus.mem_address] <= merge(ram[bus.mem_address], bus.mem_writedata, bus.mem_byteenable);
         bus.mem_readdata <= ram[bus.mem_address];
      end
   end

   // Reference memory contents, used by the random test only.
   logic [DW-1:0] shadow [0:4095] = '{default: '0};

   task automatic drive(input int m, input logic rd, input logic wr,
                        input logic [AW-1:0] a, input logic [BW-1:0] be,
                        input logic [DW-1:0] wd);
      if (m == 0) begin
         bus.m0_read = rd; bus.m0_write = wr; bus.m0_address = a;
         bus.m0_byteenable = be; bus.m0_writedata = wd;
      end else begin
         bus.m1_read = rd; bus.m1_write = wr; bus.m1_address = a;
         bus.m1_byteenable = be; bus.m1_writedata = wd;
      end
   endtask

   task automatic idle_all;
      drive(0, 1'b0, 1'b0, '0, '0, '0);
      drive(1, 1'b0, 1'b0, '0, '0, '0);
   endtask

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      drive(0, 1'b1, 1'b0, 12'h123, 4'hF, 32'h1);
      drive(1, 1'b0, 1'b1, 12'h456, 4'hF, 32'h2);
      reset = 1'b1;
      @(negedge clk);
      n_vec++;
      if ({bus.m0_waitrequest, bus.m1_waitrequest, bus.m0_readdatavalid, bus.m1_readdatavalid} !== 4'b1100) begin
         n_err++;
         $display("FAIL reset_handshake: got %b expected 1100",
                  {bus.m0_waitrequest, bus.m1_waitrequest, bus.m0_readdatavalid, bus.m1_readdatavalid});
      end
      n_vec++;
      if ({bus.mem_chipselect, bus.mem_write, bus.mem_clken} !== 3'b001) begin
         n_err++;
         $display("FAIL reset_mem_ctrl: got %b expected 001",
                  {bus.mem_chipselect, bus.mem_write, bus.mem_clken});
      end
      n_vec++;
      if ({bus.mem_address, bus.mem_byteenable, bus.mem_writedata, bus.m0_readdata, bus.m1_readdata} !== '0) begin
         n_err++;
         $display("FAIL reset_buses: got addr %h be %h wd %h rd0 %h rd1 %h expected all 0",
                  bus.mem_address, bus.mem_byteenable, bus.mem_writedata, bus.m0_readdata, bus.m1_readdata);
      end
      next_cycle;
      reset = 1'b0;
      idle_all();
   endtask

   task automatic test_single_read;
      drive(0, 1'b0, 1'b1, 12'h010, 4'hF, 32'hDEADBEEF);
      @(negedge clk);
      next_cycle;
      drive(0, 1'b1, 1'b0, 12'h010, 4'hF, 32'h0);
      @(negedge clk);
      n_vec++;
      if ({bus.m0_waitrequest, bus.m1_waitrequest, bus.mem_chipselect, bus.mem_write, bus.mem_address} !== {4'b0110, 12'h010}) begin
         n_err++;
         $display("FAIL single_read_accept: got wr0 %b wr1 %b cs %b we %b addr %h expected 0 1 1 0 010",
                  bus.m0_waitrequest, bus.m1_waitrequest, bus.mem_chipselect, bus.mem_write, bus.mem_address);
      end
      n_vec++;
      if ({bus.m0_readdatavalid, bus.m1_readdatavalid} !== 2'b00) begin
         n_err++;
         $display("FAIL write_no_rdv: got %b expected 00", {bus.m0_readdatavalid, bus.m1_readdatavalid});
      end
      next_cycle;
      idle_all();
      @(negedge clk);
      n_vec++;
      if ({bus.m0_readdatavalid, bus.m0_readdata, bus.m1_readdatavalid, bus.m1_readdata, bus.m1_waitrequest}
          !== {1'b1, 32'hDEADBEEF, 1'b0, 32'h0, 1'b1}) begin
         n_err++;
         $display("FAIL single_read_return: got rdv0 %b rd0 %h rdv1 %b rd1 %h wr1 %b expected 1 deadbeef 0 0 1",
                  bus.m0_readdatavalid, bus.m0_readdata, bus.m1_readdatavalid, bus.m1_readdata, bus.m1_waitrequest);
      end
      next_cycle;
   endtask

   task automatic test_stream;
      int            k0;
      int            k1;
      int            prev_m;
      int            exp_m;
      logic [AW-1:0] a;
      logic [DW-1:0] prev_data;
      logic [DW-1:0] got;
      for (int i = 0; i < 12; i++) begin
         a = 12'h020 + AW'(i);
         drive(0, 1'b0, 1'b1, a, 4'hF, 32'hC0DE0000 | DW'(a));
         next_cycle;
      end
      idle_all();
      reset = 1'b1;
      next_cycle;
      reset = 1'b0;
      k0 = 0; k1 = 0; prev_m = -1; prev_data = '0;
      for (int c = 0; c < 13; c++) begin
         if (c < 12) begin
            drive(0, 1'b1, 1'b0, 12'h020 + AW'(k0), 4'hF, 32'h0);
            drive(1, 1'b1, 1'b0, 12'h028 + AW'(k1), 4'hF, 32'h0);
         end else begin
            idle_all();
         end
         @(negedge clk);
         if (c < 12) begin
            exp_m = (c / 4) % 2;
            n_vec++;
            if ({bus.m0_waitrequest, bus.m1_waitrequest} !== ((exp_m == 0) ? 2'b01 : 2'b10)) begin
               n_err++;
               $display("FAIL stream_grant[%0d]: got wr0 %b wr1 %b expected master %0d",
                        c, bus.m0_waitrequest, bus.m1_waitrequest, exp_m);
            end
         end else begin
            exp_m = -1;
         end
         if (prev_m >= 0) begin
            got = (prev_m == 0) ? bus.m0_readdata : bus.m1_readdata;
            n_vec++;
            if ({bus.m0_readdatavalid, bus.m1_readdatavalid} !== ((prev_m == 0) ? 2'b10 : 2'b01) || got !== prev_data) begin
               n_err++;
               $display("FAIL stream_return[%0d]: got rdv %b data %h expected master %0d data %h",
                        c, {bus.m0_readdatavalid, bus.m1_readdatavalid}, got, prev_m, prev_data);
            end
         end
         if (exp_m == 0) begin
            prev_data = 32'hC0DE0000 | DW'(12'h020 + AW'(k0));
            k0++;
         end else if (exp_m == 1) begin
            prev_data = 32'hC0DE0000 | DW'(12'h028 + AW'(k1));
            k1++;
         end
         prev_m = exp_m;
         next_cycle;
      end
   endtask

   task automatic test_write_merge;
      drive(1, 1'b0, 1'b1, 12'hFFF, 4'hF, 32'hAAAAAAAA);
      next_cycle;
      drive(1, 1'b0, 1'b1, 12'hFFF, 4'b0011, 32'h12345678);
      @(negedge clk);
      n_vec++;
      if ({bus.m1_waitrequest, bus.mem_chipselect, bus.mem_write, bus.mem_byteenable, bus.mem_address, bus.mem_writedata}
          !== {3'b011, 4'b0011, 12'hFFF, 32'h12345678}) begin
         n_err++;
         $display("FAIL partial_write_port: got wr1 %b cs %b we %b be %b addr %h wd %h expected 0 1 1 0011 fff 12345678",
                  bus.m1_waitrequest, bus.mem_chipselect, bus.mem_write, bus.mem_byteenable,
                  bus.mem_address, bus.mem_writedata);
      end
      next_cycle;
      drive(1, 1'b0, 1'b0, '0, '0, '0);
      drive(0, 1'b1, 1'b0, 12'hFFF, 4'hF, 32'h0);
      next_cycle;
      idle_all();
      @(negedge clk);
      n_vec++;
      if ({bus.m0_readdatavalid, bus.m0_readdata} !== {1'b1, 32'hAAAA5678}) begin
         n_err++;
         $display("FAIL write_then_read: got rdv0 %b data %h expected 1 aaaa5678",
                  bus.m0_readdatavalid, bus.m0_readdata);
      end
      next_cycle;
   endtask

   task automatic test_tie_after_idle;
      drive(0, 1'b1, 1'b0, 12'h010, 4'hF, 32'h0);
      next_cycle;
      idle_all();
      next_cycle;
      drive(0, 1'b1, 1'b0, 12'h011, 4'hF, 32'h0);
      drive(1, 1'b1, 1'b0, 12'h012, 4'hF, 32'h0);
      @(negedge clk);
      n_vec++;
      if ({bus.m0_waitrequest, bus.m1_waitrequest} !== 2'b10) begin
         n_err++;
         $display("FAIL tie_after_idle_first: got wr0 %b wr1 %b expected 1 0",
                  bus.m0_waitrequest, bus.m1_waitrequest);
      end
      next_cycle;
      drive(1, 1'b0, 1'b0, '0, '0, '0);
      @(negedge clk);
      n_vec++;
      if ({bus.m0_waitrequest, bus.m1_waitrequest} !== 2'b01) begin
         n_err++;
         $display("FAIL tie_after_idle_second: got wr0 %b wr1 %b expected 0 1",
                  bus.m0_waitrequest, bus.m1_waitrequest);
      end
      next_cycle;
      idle_all();
      next_cycle;
   endtask

   task automatic test_rw_both;
      drive(0, 1'b1, 1'b1, 12'h005, 4'hF, 32'h5A5A5A5A);
      @(negedge clk);
      n_vec++;
      if ({bus.m0_waitrequest, bus.mem_chipselect, bus.mem_write, bus.mem_address} !== {3'b011, 12'h005}) begin
         n_err++;
         $display("FAIL rw_both_port: got wr0 %b cs %b we %b addr %h expected 0 1 1 005",
                  bus.m0_waitrequest, bus.mem_chipselect, bus.mem_write, bus.mem_address);
      end
      next_cycle;
      idle_all();
      @(negedge clk);
      n_vec++;
      if ({bus.m0_readdatavalid, bus.m1_readdatavalid} !== 2'b00) begin
         n_err++;
         $display("FAIL rw_both_no_rdv: got %b expected 00", {bus.m0_readdatavalid, bus.m1_readdatavalid});
      end
      next_cycle;
      drive(0, 1'b1, 1'b0, 12'h005, 4'hF, 32'h0);
      next_cycle;
      idle_all();
      @(negedge clk);
      n_vec++;
      if ({bus.m0_readdatavalid, bus.m0_readdata} !== {1'b1, 32'h5A5A5A5A}) begin
         n_err++;
         $display("FAIL rw_both_memory: got rdv0 %b data %h expected 1 5a5a5a5a",
                  bus.m0_readdatavalid, bus.m0_readdata);
      end
      next_cycle;
   endtask

   task automatic test_reset_midread;
      drive(0, 1'b1, 1'b0, 12'h010, 4'hF, 32'h0);
      @(negedge clk);
      n_vec++;
      if (bus.m0_waitrequest !== 1'b0) begin
         n_err++;
         $display("FAIL midread_accept: got wr0 %b expected 0", bus.m0_waitrequest);
      end
      #1 reset = 1'b1;
      #1;
      n_vec++;
      if ({bus.m0_waitrequest, bus.m1_waitrequest, bus.m0_readdatavalid, bus.m1_readdatavalid,
           bus.mem_chipselect, bus.mem_write, bus.mem_clken, bus.mem_address, bus.m0_readdata}
          !== {7'b1100001, 12'h000, 32'h0}) begin
         n_err++;
         $display("FAIL midread_reset_state: got wr %b%b rdv %b%b cs %b we %b clken %b addr %h rd0 %h",
                  bus.m0_waitrequest, bus.m1_waitrequest, bus.m0_readdatavalid, bus.m1_readdatavalid,
                  bus.mem_chipselect, bus.mem_write, bus.mem_clken, bus.mem_address, bus.m0_readdata);
      end
      @(posedge clk);
      #1 reset = 1'b0;
      idle_all();
      @(negedge clk);
      n_vec++;
      if ({bus.m0_readdatavalid, bus.m1_readdatavalid} !== 2'b00) begin
         n_err++;
         $display("FAIL midread_no_rdv: got %b expected 00", {bus.m0_readdatavalid, bus.m1_readdatavalid});
      end
      next_cycle;
      drive(0, 1'b1, 1'b0, 12'h011, 4'hF, 32'h0);
      drive(1, 1'b1, 1'b0, 12'h012, 4'hF, 32'h0);
      @(negedge clk);
      n_vec++;
      if ({bus.m0_waitrequest, bus.m1_waitrequest} !== 2'b01) begin
         n_err++;
         $display("FAIL post_reset_tie: got wr0 %b wr1 %b expected 0 1",
                  bus.m0_waitrequest, bus.m1_waitrequest);
      end
      next_cycle;
      idle_all();
      next_cycle;
   endtask

   task automatic test_random;
      int            m_last;
      int            m_run;
      int            g;
      bit            p_valid;
      int            p_m;
      logic [DW-1:0] p_data;
      logic          rd [2];
      logic          wr [2];
      logic [AW-1:0] a  [2];
      logic [BW-1:0] be [2];
      logic [DW-1:0] wd [2];
      logic [DW-1:0] exp_rd0;
      logic [DW-1:0] exp_rd1;
      idle_all();
      reset = 1'b1;
      next_cycle;
      reset = 1'b0;
      m_last = 1; m_run = 0; p_valid = 0; p_m = 0; p_data = '0;
      for (int n = 0; n <= 400; n++) begin
         for (int m = 0; m < 2; m++) begin
            int unsigned kind;
            kind  = $urandom_range(0, 19);
            rd[m] = (n < 400) && (kind < 7 || kind == 12);
            wr[m] = (n < 400) && (kind >= 7 && kind <= 12);
            a[m]  = 12'h100 + AW'($urandom_range(0, 15));
            be[m] = BW'($urandom_range(0, 15));
            wd[m] = DW'($urandom);
            drive(m, rd[m], wr[m], a[m], be[m], wd[m]);
         end
         if ((rd[0] | wr[0]) && (rd[1] | wr[1]))
            g = (m_run > 0 && m_run < int'(HOLD)) ? m_last : 1 - m_last;
         else if (rd[0] | wr[0]) g = 0;
         else if (rd[1] | wr[1]) g = 1;
         else g = -1;
         @(negedge clk);
         n_vec++;
         if ({bus.m0_waitrequest, bus.m1_waitrequest} !== {g != 0, g != 1}) begin
            n_err++;
            $display("FAIL rand_grant[%0d]: got wr0 %b wr1 %b expected grant %0d",
                     n, bus.m0_waitrequest, bus.m1_waitrequest, g);
         end
         n_vec++;
         if (g >= 0) begin
            if ({bus.mem_chipselect, bus.mem_write, bus.mem_address, bus.mem_byteenable, bus.mem_writedata}
                !== {1'b1, wr[g], a[g], be[g], wd[g]}) begin
               n_err++;
               $display("FAIL rand_mem_port[%0d]: got cs %b we %b addr %h be %h wd %h expected 1 %b %h %h %h",
                        n, bus.mem_chipselect, bus.mem_write, bus.mem_address, bus.mem_byteenable,
                        bus.mem_writedata, wr[g], a[g], be[g], wd[g]);
            end
         end else if ({bus.mem_chipselect, bus.mem_write, bus.mem_address, bus.mem_byteenable, bus.mem_writedata} !== '0) begin
            n_err++;
            $display("FAIL rand_mem_idle[%0d]: got cs %b we %b addr %h be %h wd %h expected all 0",
                     n, bus.mem_chipselect, bus.mem_write, bus.mem_address, bus.mem_byteenable, bus.mem_writedata);
         end
         exp_rd0 = (p_valid && p_m == 0) ? p_data : '0;
         exp_rd1 = (p_valid && p_m == 1) ? p_data : '0;
         n_vec++;
         if ({bus.m0_readdatavalid, bus.m1_readdatavalid, bus.m0_readdata, bus.m1_readdata}
             !== {p_valid && p_m == 0, p_valid && p_m == 1, exp_rd0, exp_rd1}) begin
            n_err++;
            $display("FAIL rand_return[%0d]: got rdv %b%b rd0 %h rd1 %h expected rdv %b%b rd0 %h rd1 %h",
                     n, bus.m0_readdatavalid, bus.m1_readdatavalid, bus.m0_readdata, bus.m1_readdata,
                     p_valid && p_m == 0, p_valid && p_m == 1, exp_rd0, exp_rd1);
         end
         if (g < 0) begin
            m_run   = 0;
            p_valid = 0;
         end else begin
            m_run   = (g == m_last) ? m_run + 1 : 1;
            m_last  = g;
            p_valid = rd[g] && !wr[g];
            if (p_valid) begin
               p_m    = g;
               p_data = shadow[a[g]];
            end
            if (wr[g]) shadow[a[g]] = merge(shadow[a[g]], wd[g], be[g]);
         end
         next_cycle;
      end
      idle_all();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      idle_all();
      reset = 1'b1;
      next_cycle;
      next_cycle;
      reset = 1'b0;
      test_reset();
      test_single_read();
      test_stream();
      test_write_merge();
      test_tie_after_idle();
      test_rw_both();
      test_reset_midread();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/nios_memory_arbiter.md
NIOS_MEMORY_ARBITER -- requirements
Module: nios_memory_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12, word-address width of shared on-chip RAM.
REQ-002 Parameter DATA_W, default 32, data width; byteenable width is DATA_W/8.
REQ-003 Parameter HOLD_MAX, default 4, maximum consecutive accepted beats per master while the other master waits (range 1..15).
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 mN_address  in  ADDR_W  word address, master N (N = 0, 1).
REQ-007 mN_byteenable  in  DATA_W/8  byte lanes for writes, master N.
REQ-008 mN_read / mN_write  in  1 each  transfer request, master N; both high is illegal.
REQ-009 mN_writedata  in  DATA_W  write data, master N.
REQ-010 mN_waitrequest  out  1  high = request not accepted this cycle.
REQ-011 mN_readdata  out  DATA_W  read data, master N.
REQ-012 mN_readdatavalid  out  1  one-cycle strobe qualifying mN_readdata.
REQ-013 mem_address, mem_byteenable, mem_writedata  out  ADDR_W, DATA_W/8, DATA_W  to RAM port.
REQ-014 mem_chipselect, mem_write, mem_clken  out  1 each  to RAM port; mem_clken tied high.
REQ-015 mem_readdata  in  DATA_W  RAM output, valid the cycle after the address edge.

Function
REQ-016 A master requests when mN_read or mN_write is high; exactly one request is accepted per cycle at most.
REQ-017 Acceptance: granted master sees mN_waitrequest low in the same cycle; non-granted requester sees waitrequest high; idle master sees waitrequest high.
REQ-018 Memory-side outputs shall be a combinational mux of the granted master's signals; mem_chipselect = accepted read or write; mem_write = accepted write; with no grant all mem_* outputs 0.
REQ-019 Arbitration: if only one master requests, it is granted.
REQ-020 If both request: current owner keeps the grant while hold_cnt < HOLD_MAX; otherwise grant goes to the master not granted last (round-robin).
REQ-021 hold_cnt (4 bits) increments on each accepted beat by the same owner, loads 1 on an owner change, clears when no beat is accepted.
REQ-022 last_grant register updates to the accepting master on every accepted beat.
REQ-023 Read latency: accepted read at cycle t -> mN_readdatavalid high at t+1 with mN_readdata = mem_readdata; issuing master held in registered rd_owner/rd_pend.
REQ-024 Back-to-back reads (any master mix) sustain one beat per cycle; each returns in order at t+1.
REQ-025 Write followed by read of same address in the next cycle returns the new data.
REQ-026 Writes produce no readdatavalid.
REQ-027 Both mN_read and mN_write high: treated as a write; readdatavalid not generated.
REQ-028 Out-of-range addresses do not exist (full ADDR_W space mapped); address passed unchanged.

Reset
REQ-029 On reset assertion, immediately: rd_pend = 0, last_grant = 1 (so master 0 wins first tie), hold_cnt = 0.
REQ-030 During reset both mN_waitrequest = 1, mN_readdatavalid = 0, mN_readdata = 0, all mem_* outputs 0 except mem_clken = 1.
REQ-031 A read accepted in the cycle reset asserts returns no readdatavalid.

Structure
REQ-032 Shared package holds: grant/owner enum (GRANT_M0, GRANT_M1), HOLD counter width constant, default ADDR_W/DATA_W.
REQ-033 One sub-module: nios_rr_arbiter (2-requester round-robin with hold counter, outputs one-hot grant); datapath muxing stays in top.

Verification
REQ-034 M0 read addr 0x010 alone, RAM holds 0xDEADBEEF -> m0_waitrequest low same cycle, m0_readdatavalid one cycle later with 0xDEADBEEF; m1 outputs idle.
REQ-035 Both masters stream continuous reads, HOLD_MAX=4, from reset -> accept order M0 x4, M1 x4, M0 x4; one beat every cycle; each readdatavalid routed to issuer.
REQ-036 M1 write 0x12345678 byteenable 0b0011 to addr 0xFFF (prior 0xAAAAAAAA), then M0 read 0xFFF next cycle -> M0 receives 0xAAAA5678.
REQ-037 Both request single beats in same cycle after idle with last_grant=M0 -> M1 granted first, M0 next cycle.
REQ-038 Assert reset in cycle an M0 read is accepted -> no m0_readdatavalid; after release, first tie goes to M0; all reset values per REQ-030.
REQ-039 M0 write and read both high to addr 0x005 -> treated as write, memory updated, no readdatavalid.
